// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store initiator driving the Memoria data memory pins.
// Latency: a memory access takes one cycle (accept -> LOAD/STORE -> RESP), so 1 access per 3 cycles.
// Backpressure: req_ready only in IDLE; a stalled rsp_ready holds RESP and blocks new requests.
// Optional feature: define LSU_ADDR_CHECK_EN to reject misaligned word and out-of-range requests.
module lsu_mem_port #(
  parameter int ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_ad,
  output logic [31:0] mem_di,
  output logic        mem_we,
  output logic        mem_re,
  output logic        mem_byte_l,
  output logic        mem_byte_s,
  input  logic [31:0] mem_do,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_LIMIT_W = 32'(ADDR_LIMIT);

  state_t      state_q;
  state_t      state_d;

  // Request captured at acceptance; the memory pins are decoded only from these.
  logic        lat_we;
  logic        lat_byte;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        accept;
  logic        access_done;
  logic        misalign;
  logic        addr_oor;
  logic        chk_fail;

  assign accept      = (state_q == IDLE) && req_valid;
  assign access_done = (state_q == LOAD) || (state_q == STORE);

  // Address screening terms; only consulted when the check is built in.
  assign misalign = !req_byte && (req_addr[1:0] != 2'b00);
  assign addr_oor = (req_addr >= ADDR_LIMIT_W);

`ifdef LSU_ADDR_CHECK_EN
  logic err_q;

  assign chk_fail = misalign || addr_oor;
  assign rsp_err  = err_q;

  // Error flag: set by a rejected request, cleared when the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= chk_fail;
    end else if ((state_q == RESP) && rsp_ready) begin
      err_q <= 1'b0;
    end
  end
`else
  // Without the check every address goes to memory as-is; the terms are left dangling.
  logic unused_chk;

  assign unused_chk = misalign | addr_oor;
  assign chk_fail   = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake/strobe decode from the current state.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_byte_l = 1'b0;
    mem_byte_s = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (chk_fail) begin
            state_d = RESP;
          end else if (req_we) begin
            state_d = STORE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        mem_re     = 1'b1;
        mem_byte_l = lat_byte;
        state_d    = RESP;
      end
      STORE: begin
        mem_we     = lat_we;
        mem_byte_s = lat_byte;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the request on acceptance; address/data keep driving the memory afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_byte  <= req_byte;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  assign mem_ad = lat_addr;
  assign mem_di = lat_wdata;

  // Response data: cleared on accept so stores and errors return 0, loaded at the end of LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'h0;
    end else if (accept) begin
      rsp_rdata <= 32'h0;
    end else if (state_q == LOAD) begin
      rsp_rdata <= lat_byte ? {24'h0, mem_do[7:0]} : mem_do;
    end
  end

  // Completed-access counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= 16'h0;
    end else if (access_done) begin
      txn_count <= txn_count + 16'h1;
    end
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator that sits between the execute stage and the data memory `Memoria`. It accepts one load or store request at a time over a valid/ready handshake. It drives the memory's `ad/di/we/re/byte_l/byte_s` pins using the memory's write-on-posedge, read-on-negedge timing. It then returns read data or a completion/error status over a second valid/ready handshake.

## Interface
Parameters:
- `ADDR_LIMIT`, default 1024: byte size of the data memory; addresses at or above it are out of range (checked only with `LSU_ADDR_CHECK_EN`).

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  1 = byte access, 0 = word access.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; for a byte store only `[7:0]` is used.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  load data, already zero-extended for byte loads; 0 for stores and errors.
- `rsp_err`  out  1  request rejected; no memory access was made.
- `mem_ad`  out  32  to memory `ad`.
- `mem_di`  out  32  to memory `di`.
- `mem_we`  out  1  to memory `we`.
- `mem_re`  out  1  to memory `re`.
- `mem_byte_l`  out  1  to memory `byte_l`.
- `mem_byte_s`  out  1  to memory `byte_s`.
- `mem_do`  in  32  from memory `d_o`.
- `txn_count`  out  16  count of completed (non-error) memory accesses; wraps from 0xFFFF to 0.

## Operation
- FSM with states IDLE, LOAD, STORE, RESP; reset state IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch `req_we`, `req_byte`, `req_addr`, `req_wdata`.
  - If the check fails (see Configuration), set the error flag and go to RESP.
  - Else go to STORE if `req_we`=1, else LOAD.
- **LOAD**
  - `mem_re`=1, `mem_ad`=latched address, `mem_byte_l`=latched byte flag.
  - At the posedge ending this state: capture `mem_do` into `rsp_rdata`, increment `txn_count`, go to RESP.
- **STORE**
  - `mem_we`=1, `mem_ad`=latched address, `mem_di`=latched data, `mem_byte_s`=latched byte flag.
  - Increment `txn_count` at the posedge ending this state, then go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`=1: clear the error flag and go to IDLE.
- `req_ready`=0 in every state except IDLE. Requests presented outside IDLE are ignored, not queued.
- All `mem_*` outputs are decoded only from the state register and the latched request. There is no combinational path from `req_*` to `mem_*`.
- Outside LOAD and STORE: `mem_we`=`mem_re`=`mem_byte_l`=`mem_byte_s`=0. `mem_ad` and `mem_di` hold their latched values.
- Byte semantics match the memory:
  - A byte store writes `req_wdata[7:0]` into bits [7:0] of word `addr[9:2]`.
  - A byte load returns bits [7:0] of that word, zero-extended.
  - `addr[1:0]` never selects a lane.

## Timing
- Request accepted at posedge E0.
- The memory access occupies cycle E0..E1:
  - Store: the memory writes at E1.
  - Load: the memory updates `d_o` at the negedge mid-cycle, and the block captures it at E1.
- `rsp_valid` is high from E1.
- With `rsp_ready` tied high, RESP lasts one cycle and the next request is accepted at E2. Throughput is 1 access per 3 cycles.
- Error path: accept at E0, `rsp_valid` high from E0 (RESP entered directly); no `mem_*` strobe asserts.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, all `mem_*`=0, `txn_count`=0.
- **Reset during STORE or LOAD:**
  - `mem_we` and `mem_re` drop immediately (asynchronous), so the write does not occur.
  - No response is produced and `txn_count` does not increment.
- **Back-to-back:** a new request is accepted in the same cycle IDLE is entered. A request held high across RESP is accepted on the first IDLE cycle.

## Configuration
- Macro `LSU_ADDR_CHECK_EN`.
- **Defined:** a request fails the check when either of these holds:
  - it is a word access with `req_addr[1:0]`≠0;
  - `req_addr` ≥ `ADDR_LIMIT`.
  - A failed request returns `rsp_err`=1 and `rsp_rdata`=0, with no memory access and no `txn_count` increment.
- **Undefined:** every request passes the check and `rsp_err` is tied to 0. A misaligned or out-of-range address goes to memory unchanged, where `[1:0]` is ignored and `[9:2]` aliases.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 → `mem_we` high for exactly one cycle; the load returns `rsp_rdata`=0xDEADBEEF; `txn_count`=2.
- Byte store 0x...5A to 0x10 over 0xDEADBEEF, then byte load 0x10 and word load 0x10 → byte load returns 0x0000005A; word load returns 0xDEADBE5A.
- `rsp_ready` held low for 5 cycles after a load → `rsp_valid` and `rsp_rdata` stay stable; `req_ready`=0 throughout; a second request presented meanwhile is accepted only after the handshake.
- With `LSU_ADDR_CHECK_EN`: word load at 0x13 and word load at 0x400 (`ADDR_LIMIT`=1024) → `rsp_err`=1, `rsp_rdata`=0, `mem_re` never asserted, `txn_count` unchanged.
  - Without the macro: the same load at 0x13 returns the word at 0x10 with `rsp_err`=0.
- `rst_n` pulsed low during STORE of 0x12345678 to 0x20 → no write occurs (a later load of 0x20 returns the prior value); all outputs are at reset values; `txn_count`=0.
- With `rsp_ready` tied high, 0xFFFF accesses followed by one more → `txn_count` wraps to 0; new requests are accepted every 3rd cycle.
